// File: rtl/sp_ram_pkg.sv
// Shared definitions for the byte-enabled scratch RAM: read-during-write
// policy codes, clear-engine state encoding and the byte-lane merge helper.
package sp_ram_pkg;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    // One byte lane of a partial write: new byte when enabled, old byte otherwise.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sp_ram_clear_fsm.sv
// Clear engine: owns the array after reset or a clear request and sweeps a
// zero write across every address, one word per cycle.
module sp_ram_clear_fsm
    import sp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State and sweep counter; reset always restarts a full clear from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and clear-port outputs; clr_req is ignored while clearing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sp_ram_be_ctrl.sv
// Simple dual-port RAM (one write, one read port) with byte-lane write
// enables, selectable same-address read-during-write policy, a read-valid
// strobe and a built-in clear engine.
// Optional macro SP_RAM_OUT_REG_EN adds an output register stage on
// rdata/rvalid (read latency 2 instead of 1).
module sp_ram_be_ctrl
    import sp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    init_busy,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    sp_ram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_en = we & ~init_busy;
    assign rd_en = re & ~init_busy;

    // Array write: the clear engine has priority, otherwise byte-merged user writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                mem[waddr][8*i +: 8] <= merge_byte(mem[waddr][8*i +: 8],
                                                   wdata[8*i +: 8], be[i]);
            end
        end
    end

    // Read word selection; write-through mode forwards enabled lanes on a collision.
    always_comb begin
        rd_word = mem[raddr];
        if (RDW_MODE == RDW_NEW && wr_en && waddr == raddr) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                rd_word[8*i +: 8] = merge_byte(mem[raddr][8*i +: 8],
                                               wdata[8*i +: 8], be[i]);
            end
        end
    end

    // First read stage: capture on accepted reads, data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_word;
            end
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;

    // Output pipeline stage: delays data and strobe one cycle, data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= rvalid_q;
            if (rvalid_q) begin
                rdata_o <= rdata_q;
            end
        end
    end

    assign rdata  = rdata_o;
    assign rvalid = rvalid_o;
`else
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sp_ram_be_ctrl.sv
// Directed self-checking bench for sp_ram_be_ctrl. Two instances share all
// inputs: dut0 uses read-first collisions, dut1 uses write-through.
module tb_sp_ram_be_ctrl;

`ifdef SP_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic [3:0]  raddr = '0;

    logic        busy0, busy1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;

    int n_tests = 0;
    int n_fail  = 0;

    sp_ram_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy0),
        .we(we), .be(be), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0)
    );

    sp_ram_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(busy1),
        .we(we), .be(be), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: called and returning at posedge+1.
    task automatic do_write(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
        we = 1'b1; waddr = a; be = b; wdata = d;
        @(posedge clk); #1;
        we = 1'b0; be = '0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic v0, output logic [31:0] d0,
                           output logic v1, output logic [31:0] d1);
        re = 1'b1; raddr = a;
        @(posedge clk); #1;
        re = 1'b0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        v0 = rvalid0; d0 = rdata0; v1 = rvalid1; d1 = rdata1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        logic v0, v1;
        logic [31:0] d0, d1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        n_tests++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b/%b want 1", busy0, busy1); end
        n_tests++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b/%b want 0", rvalid0, rvalid1); end
        n_tests++; if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0", rdata0, rdata1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL reset_clear_len got %0d want 16", n); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1_low got %b want 0", busy1); end
        for (int a = 0; a < 16; a++) begin
            do_read(4'(a), v0, d0, v1, d1);
            n_tests++;
            if (v0 !== 1'b1 || d0 !== 32'h0 || v1 !== 1'b1 || d1 !== 32'h0) begin
                n_fail++; $display("FAIL init_zero addr %0d got %b:%h %b:%h want 1:00000000", a, v0, d0, v1, d1);
            end
        end
    endtask

    task automatic test_latency;
        re = 1'b1; raddr = 4'd2;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            re = 1'b0;
            n_tests++;
            if (rvalid0 !== (c == LAT)) begin n_fail++; $display("FAIL latency cycle %0d rvalid got %b want %b", c, rvalid0, (c == LAT)); end
        end
    endtask

    task automatic test_byte_enable;
        logic v0, v1;
        logic [31:0] d0, d1;
        do_write(4'd3, 4'b1111, 32'hDEADBEEF);
        do_write(4'd3, 4'b0101, 32'h11223344);
        do_read(4'd3, v0, d0, v1, d1);
        n_tests++; if (v0 !== 1'b1 || d0 !== 32'hDE22BE44 || d1 !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_enable got %b:%h/%h want 1:de22be44", v0, d0, d1); end
        do_write(4'd3, 4'b0000, 32'hFFFFFFFF);
        do_read(4'd3, v0, d0, v1, d1);
        n_tests++; if (d0 !== 32'hDE22BE44 || d1 !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_zero_noop got %h/%h want de22be44", d0, d1); end
    endtask

    task automatic test_collision;
        logic v0, v1;
        logic [31:0] d0, d1;
        do_write(4'd5, 4'b1111, 32'hAAAAAAAA);
        we = 1'b1; re = 1'b1; waddr = 4'd5; raddr = 4'd5; wdata = 32'h55555555; be = 4'b0011;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; be = '0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        n_tests++; if (rvalid0 !== 1'b1 || rdata0 !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL rdw_old got %b:%h want 1:aaaaaaaa", rvalid0, rdata0); end
        n_tests++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hAAAA5555) begin n_fail++; $display("FAIL rdw_new got %b:%h want 1:aaaa5555", rvalid1, rdata1); end
        @(posedge clk); #1;
        n_tests++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rvalid_strobe got %b/%b want 0", rvalid0, rvalid1); end
        do_read(4'd5, v0, d0, v1, d1);
        n_tests++; if (d0 !== 32'hAAAA5555 || d1 !== 32'hAAAA5555) begin n_fail++; $display("FAIL post_collision got %h/%h want aaaa5555", d0, d1); end
    endtask

    task automatic test_diff_addr;
        logic v0, v1;
        logic [31:0] d0, d1;
        we = 1'b1; waddr = 4'd9; wdata = 32'hCAFEF00D; be = 4'b1111;
        re = 1'b1; raddr = 4'd3;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0; be = '0;
        repeat (LAT - 1) begin @(posedge clk); #1; end
        n_tests++; if (rdata0 !== 32'hDE22BE44 || rdata1 !== 32'hDE22BE44) begin n_fail++; $display("FAIL diff_addr_read got %h/%h want de22be44", rdata0, rdata1); end
        do_read(4'd9, v0, d0, v1, d1);
        n_tests++; if (d0 !== 32'hCAFEF00D || d1 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL diff_addr_write got %h/%h want cafef00d", d0, d1); end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  addrs [4];
        logic [31:0] exp   [4];
        int idx;
        addrs[0] = 4'd3; exp[0] = 32'hDE22BE44;
        addrs[1] = 4'd5; exp[1] = 32'hAAAA5555;
        addrs[2] = 4'd9; exp[2] = 32'hCAFEF00D;
        addrs[3] = 4'd0; exp[3] = 32'h00000000;
        for (int c = 0; c < 4 + LAT; c++) begin
            if (c < 4) begin re = 1'b1; raddr = addrs[c]; end
            else re = 1'b0;
            @(posedge clk); #1;
            idx = c - LAT + 1;
            n_tests++;
            if (idx >= 0 && idx < 4) begin
                if (rvalid0 !== 1'b1 || rdata0 !== exp[idx] || rdata1 !== exp[idx]) begin
                    n_fail++; $display("FAIL b2b idx %0d got %b:%h/%h want 1:%h", idx, rvalid0, rdata0, rdata1, exp[idx]);
                end
            end else if (rvalid0 !== 1'b0) begin
                n_fail++; $display("FAIL b2b_idle cycle %0d rvalid got %b want 0", c, rvalid0);
            end
        end
        re = 1'b0;
        exp[0] = 32'hDEADBEEF;
        do_write(4'd3, 4'b1111, exp[0]);
        n_tests++; if (rvalid0 !== 1'b0 || rdata0 !== exp[3]) begin n_fail++; $display("FAIL rdata_hold got %b:%h want 0:%h", rvalid0, rdata0, exp[3]); end
    endtask

    task automatic test_clear_req;
        int k;
        logic v0, v1;
        logic [31:0] d0, d1;
        do_write(4'd7, 4'b1111, 32'h12345678);
        clr_req = 1'b1; re = 1'b1; raddr = 4'd7;
        @(posedge clk); #1;
        clr_req = 1'b0;
        we = 1'b1; be = 4'b1111; waddr = 4'd7; wdata = 32'hFFFFFFFF;
        k = 1;
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise got %b want 1", busy0); end
        while (busy0 === 1'b1 && k < 100) begin
            n_tests++;
            if (rvalid0 !== (k == LAT)) begin n_fail++; $display("FAIL clr_rvalid k %0d got %b want %b", k, rvalid0, (k == LAT)); end
            if (k >= LAT) begin
                n_tests++;
                if (rdata0 !== 32'h12345678) begin n_fail++; $display("FAIL clr_rdata_hold k %0d got %h want 12345678", k, rdata0); end
            end
            clr_req = (k == 8);
            @(posedge clk); #1;
            k++;
        end
        we = 1'b0; re = 1'b0; be = '0; clr_req = 1'b0;
        n_tests++; if (k !== 17) begin n_fail++; $display("FAIL clr_len got %0d want 17", k); end
        n_tests++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL clr_end_rvalid got %b want 0", rvalid0); end
        do_read(4'd7, v0, d0, v1, d1);
        n_tests++; if (v0 !== 1'b1 || d0 !== 32'h0 || d1 !== 32'h0) begin n_fail++; $display("FAIL clr_zeroed got %b:%h/%h want 1:00000000", v0, d0, d1); end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        logic v0, v1;
        logic [31:0] d0, d1;
        do_write(4'd12, 4'b1111, 32'hA5A5A5A5);
        do_read(4'd12, v0, d0, v1, d1);
        n_tests++; if (d0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL pre_reset_read got %h want a5a5a5a5", d0); end
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 32'h0) begin n_fail++; $display("FAIL mid_clear_reset got %b:%b:%h want 1:0:00000000", busy0, rvalid0, rdata0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_busy(n);
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL restart_clear_len got %0d want 16", n); end
        do_read(4'd12, v0, d0, v1, d1);
        n_tests++; if (v0 !== 1'b1 || d0 !== 32'h0) begin n_fail++; $display("FAIL restart_zeroed got %b:%h want 1:00000000", v0, d0); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_byte_enable();
        test_collision();
        test_diff_addr();
        test_back_to_back();
        test_clear_req();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
